// File: rtl/riscv_v_pkg.sv
// rtl/riscv_v_pkg.sv - shared element-width and opcode types for the vector add pipeline
package riscv_v_pkg;

  typedef enum logic [1:0] {
    SEW_E8  = 2'b00,
    SEW_E16 = 2'b01,
    SEW_E32 = 2'b10,
    SEW_E64 = 2'b11
  } sew_e;

  typedef enum logic [1:0] {
    VOP_ADD  = 2'b00,
    VOP_SUB  = 2'b01,
    VOP_RSUB = 2'b10,
    VOP_RSVD = 2'b11
  } vadd_op_e;

  function automatic int unsigned elem_count(input int unsigned vlen, input sew_e sew);
    return vlen >> (3 + int'(sew));
  endfunction

endpackage

// File: rtl/vector_add_segmented.sv
// rtl/vector_add_segmented.sv - combinational per-element add/sub with carries confined to each SEW element
module vector_add_segmented
  import riscv_v_pkg::*;
#(
  parameter int VLEN = 128
) (
  input  logic [VLEN-1:0] vs2,
  input  logic [VLEN-1:0] vs1,
  input  vadd_op_e        op,
  input  sew_e            sew,
  output logic [VLEN-1:0] result
);

  localparam int NB = VLEN / 8;

  logic [VLEN-1:0] opa;
  logic [VLEN-1:0] opb;
  logic            cin;

  always_comb begin
    opa = vs2;
    opb = vs1;
    cin = 1'b0;
    case (op)
      VOP_SUB:  begin opb = ~vs1; cin = 1'b1; end
      VOP_RSUB: begin opa = vs1; opb = ~vs2; cin = 1'b1; end
      default:  ;
    endcase
  end

  // Byte-wise ripple; the chain restarts with cin at each element's first byte.
  always_comb begin
    logic        carry;
    logic [8:0]  sum9;
    int unsigned bmask;
    carry  = 1'b0;
    sum9   = '0;
    result = '0;
    bmask  = (32'd1 << sew) - 32'd1;
    for (int unsigned b = 0; b < NB; b++) begin
      if ((b & bmask) == 0) carry = cin;
      sum9 = {1'b0, opa[b*8 +: 8]} + {1'b0, opb[b*8 +: 8]} + {8'd0, carry};
      result[b*8 +: 8] = sum9[7:0];
      carry = sum9[8];
    end
  end

endmodule

// File: rtl/vector_add_pipe.sv
// rtl/vector_add_pipe.sv - pipelined masked vector add/sub/rsub with valid/ready backpressure
module vector_add_pipe
  import riscv_v_pkg::*;
#(
  parameter int VLEN   = 128,
  parameter int STAGES = 2,
  parameter int VL_W   = $clog2(VLEN/8) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [1:0]      sew,
  input  logic            vm,
  input  logic [VL_W-1:0] vl,
  input  logic [VLEN-1:0] vs2,
  input  logic [VLEN-1:0] vs1,
  input  logic [VLEN-1:0] v0,
  input  logic [VLEN-1:0] vd_old,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [VLEN-1:0] vd
);

  localparam int NB = VLEN / 8;
  localparam int NR = STAGES - 1;

  logic            s1_valid;
  vadd_op_e        s1_op;
  sew_e            s1_sew;
  logic            s1_vm;
  logic [VL_W-1:0] s1_vl;
  logic [VLEN-1:0] s1_vs2;
  logic [VLEN-1:0] s1_vs1;
  logic [VLEN-1:0] s1_v0;
  logic [VLEN-1:0] s1_vd_old;
  logic            s1_load;

  logic [NR-1:0]   r_valid;
  logic [NR-1:0]   r_load;
  logic [VLEN-1:0] r_data [NR];

  logic [VLEN-1:0] raw;
  logic [VLEN-1:0] merged;

  // Ready ripples back from the consumer: a stage loads if empty or its successor loads.
  always_comb begin
    logic adv;
    adv    = out_ready;
    r_load = '0;
    for (int j = NR - 1; j >= 0; j--) begin
      r_load[j] = !r_valid[j] || adv;
      adv       = r_load[j];
    end
    s1_load = !s1_valid || adv;
  end

  assign in_ready = s1_load;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_op     <= VOP_ADD;
      s1_sew    <= SEW_E8;
      s1_vm     <= 1'b0;
      s1_vl     <= '0;
      s1_vs2    <= '0;
      s1_vs1    <= '0;
      s1_v0     <= '0;
      s1_vd_old <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op     <= vadd_op_e'(op);
        s1_sew    <= sew_e'(sew);
        s1_vm     <= vm;
        s1_vl     <= vl;
        s1_vs2    <= vs2;
        s1_vs1    <= vs1;
        s1_v0     <= v0;
        s1_vd_old <= vd_old;
      end
    end
  end

  vector_add_segmented #(.VLEN(VLEN)) u_seg (
    .vs2    (s1_vs2),
    .vs1    (s1_vs1),
    .op     (s1_op),
    .sew    (s1_sew),
    .result (raw)
  );

  // Tail and masked-off elements keep the old destination bits.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    merged = s1_vd_old;
    for (int unsigned b = 0; b < NB; b++) begin
      idx = b >> s1_sew;
      if (idx < 32'(s1_vl) && (s1_vm || s1_v0[idx])) merged[b*8 +: 8] = raw[b*8 +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int j = 0; j < NR; j++) begin
        r_valid[j] <= 1'b0;
        r_data[j]  <= '0;
      end
    end else begin
      if (r_load[0]) begin
        r_valid[0] <= s1_valid;
        if (s1_valid) r_data[0] <= merged;
      end
      for (int j = 1; j < NR; j++) begin
        if (r_load[j]) begin
          r_valid[j] <= r_valid[j-1];
          if (r_valid[j-1]) r_data[j] <= r_data[j-1];
        end
      end
    end
  end

  assign out_valid = r_valid[NR-1];
  assign vd        = r_data[NR-1];

endmodule

// File: tb/tb_vector_add_pipe.sv
// tb/tb_vector_add_pipe.sv - self-checking bench for vector_add_pipe at STAGES=2 and STAGES=4
module tb_vector_add_pipe;
  import riscv_v_pkg::*;

  localparam int VLEN = 128;
  localparam int VL_W = $clog2(VLEN/8) + 1;
  localparam int NT   = 11;

  typedef struct {
    logic [1:0]      op;
    logic [1:0]      sew;
    logic            vm;
    logic [VL_W-1:0] vl;
    logic [VLEN-1:0] vs2;
    logic [VLEN-1:0] vs1;
    logic [VLEN-1:0] v0;
    logic [VLEN-1:0] vd_old;
    logic [VLEN-1:0] exp;
  } vec_t;

  logic            clock;
  logic            reset;
  logic            in_valid;
  logic            out_ready;
  logic            vm;
  logic [1:0]      op;
  logic [1:0]      sew;
  logic [VL_W-1:0] vl;
  logic [VLEN-1:0] vs2, vs1, v0, vd_old;
  logic            sel;

  logic            iv2, iv4, or2, or4, ir2, ir4, ov2, ov4;
  logic [VLEN-1:0] vd2, vd4;
  logic            cur_ir, cur_ov, cur_or;
  logic [VLEN-1:0] cur_vd;

  assign iv2    = in_valid && !sel;
  assign iv4    = in_valid && sel;
  assign or2    = sel ? 1'b1 : out_ready;
  assign or4    = sel ? out_ready : 1'b1;
  assign cur_ir = sel ? ir4 : ir2;
  assign cur_ov = sel ? ov4 : ov2;
  assign cur_or = sel ? or4 : or2;
  assign cur_vd = sel ? vd4 : vd2;

  vector_add_pipe #(.VLEN(VLEN), .STAGES(2)) dut2 (
    .clock(clock), .reset(reset), .in_valid(iv2), .in_ready(ir2), .op(op), .sew(sew),
    .vm(vm), .vl(vl), .vs2(vs2), .vs1(vs1), .v0(v0), .vd_old(vd_old),
    .out_valid(ov2), .out_ready(or2), .vd(vd2)
  );

  vector_add_pipe #(.VLEN(VLEN), .STAGES(4)) dut4 (
    .clock(clock), .reset(reset), .in_valid(iv4), .in_ready(ir4), .op(op), .sew(sew),
    .vm(vm), .vl(vl), .vs2(vs2), .vs1(vs1), .v0(v0), .vd_old(vd_old),
    .out_valid(ov4), .out_ready(or4), .vd(vd4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int              checks;
  int              errors;
  int              n_acc;
  int              n_out;
  logic            mon_en;
  logic            held;
  logic [VLEN-1:0] held_vd;
  logic [VLEN-1:0] exp_q [$];
  vec_t            tbl [NT];

  task automatic check(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: element-at-a-time arithmetic on extracted integers.
  function automatic logic [VLEN-1:0] model(input logic [1:0] mop, input logic [1:0] msew,
      input logic mvm, input logic [VL_W-1:0] mvl, input logic [VLEN-1:0] a_v,
      input logic [VLEN-1:0] b_v, input logic [VLEN-1:0] m_v, input logic [VLEN-1:0] old_v);
    int unsigned     ew, n;
    logic [63:0]     msk, a, b, r;
    logic [VLEN-1:0] res;
    ew  = 8 << msew;
    n   = elem_count(VLEN, sew_e'(msew));
    msk = (ew == 64) ? '1 : ((64'd1 << ew) - 64'd1);
    res = old_v;
    for (int unsigned i = 0; i < n; i++) begin
      a = 64'(a_v >> (i*ew)) & msk;
      b = 64'(b_v >> (i*ew)) & msk;
      case (mop)
        2'd1:    r = a - b;
        2'd2:    r = b - a;
        default: r = a + b;
      endcase
      r = r & msk;
      if (i < 32'(mvl) && (mvm || m_v[i]))
        res = (res & ~(VLEN'(msk) << (i*ew))) | (VLEN'(r) << (i*ew));
    end
    return res;
  endfunction

  // Scoreboard: acceptances push the model result, completions pop in FIFO order.
  initial forever begin
    @(negedge clock);
    if (mon_en) begin
      if (held) begin
        check("hold_valid", VLEN'(cur_ov), VLEN'(1));
        check("hold_vd", cur_vd, held_vd);
      end
      if (cur_ov && cur_or) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_output: got %h expected no result", cur_vd);
        end else begin
          check("vd_order", cur_vd, exp_q.pop_front());
        end
        n_out++;
      end
      if (in_valid && cur_ir) begin
        exp_q.push_back(model(op, sew, vm, vl, vs2, vs1, v0, vd_old));
        n_acc++;
      end
      held    = cur_ov && !cur_or;
      held_vd = cur_vd;
    end else begin
      held = 1'b0;
    end
  end

  task automatic apply(input vec_t v);
    op = v.op; sew = v.sew; vm = v.vm; vl = v.vl;
    vs2 = v.vs2; vs1 = v.vs1; v0 = v.v0; vd_old = v.vd_old;
  endtask

  task automatic rand_bundle();
    op     = 2'($urandom);
    sew    = 2'($urandom);
    vm     = 1'($urandom);
    vl     = VL_W'($urandom_range(0, 20));
    vs2    = {$urandom, $urandom, $urandom, $urandom};
    vs1    = {$urandom, $urandom, $urandom, $urandom};
    v0     = {$urandom, $urandom, $urandom, $urandom};
    vd_old = {$urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(0, 3) == 0) vs2 = '1;
  endtask

  task automatic run_vec(input int idx, input int lat_exp);
    logic acc;
    logic got;
    int   lat;
    apply(tbl[idx]);
    in_valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) begin
      @(negedge clock);
      acc = cur_ir;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    check($sformatf("vec%0d_accept", idx), VLEN'(acc), VLEN'(1));
    got = 1'b0;
    lat = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      got = cur_ov;
    end
    check($sformatf("vec%0d_latency", idx), VLEN'(lat), VLEN'(lat_exp));
    check($sformatf("vec%0d_vd", idx), cur_vd, tbl[idx].exp);
    @(posedge clock); #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      @(posedge clock); #1;
    end
    check("drain_empty", VLEN'(exp_q.size()), VLEN'(0));
  endtask

  task automatic rand_run(input int ncyc);
    logic acc;
    mon_en = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clock);
      acc = in_valid && cur_ir;
      @(posedge clock); #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rand_bundle();
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    drain();
    mon_en = 1'b0;
  endtask

  task automatic bp_test(input int s);
    int   a0, o0, sent;
    logic acc;
    mon_en    = 1'b1;
    a0        = n_acc;
    o0        = n_out;
    out_ready = 1'b0;
    for (int k = 0; k < s; k++) begin
      rand_bundle();
      in_valid = 1'b1;
      @(negedge clock);
      check("bp_accept", VLEN'(cur_ir), VLEN'(1));
      @(posedge clock); #1;
    end
    rand_bundle();
    in_valid = (s < 4);
    repeat (3) begin
      @(negedge clock);
      check("bp_full_ready", VLEN'(cur_ir), VLEN'(0));
      check("bp_out_valid", VLEN'(cur_ov), VLEN'(1));
      @(posedge clock); #1;
    end
    check("bp_held_count", VLEN'(n_acc - a0), VLEN'(s));
    out_ready = 1'b1;
    sent = s;
    for (int t = 0; t < 30 && sent < 4; t++) begin
      @(negedge clock);
      acc = cur_ir;
      @(posedge clock); #1;
      if (acc) begin
        sent++;
        rand_bundle();
        in_valid = (sent < 4);
      end
    end
    drain();
    check("bp_out_count", VLEN'(n_out - o0), VLEN'(4));
    mon_en = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; n_acc = 0; n_out = 0;
    mon_en = 1'b0; held = 1'b0; held_vd = '0;
    sel = 1'b0; reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; sew = '0; vm = 1'b1; vl = '0; vs2 = '0; vs1 = '0; v0 = '0; vd_old = '0;

    tbl[0]  = '{2'd0, 2'd0, 1'b1, 5'd16, {16{8'hFF}}, {16{8'h01}}, '0,
                {16{8'h5A}}, '0};
    tbl[1]  = '{2'd1, 2'd2, 1'b1, 5'd4, '0, {4{32'h1}}, '0,
                {4{32'h12345678}}, {4{32'hFFFFFFFF}}};
    tbl[2]  = '{2'd2, 2'd2, 1'b1, 5'd4, '0, {4{32'h1}}, '0,
                {4{32'h12345678}}, {4{32'h1}}};
    tbl[3]  = '{2'd0, 2'd2, 1'b0, 5'd4, {4{32'h1}}, {4{32'h1}}, 128'b0101,
                {4{32'hAAAAAAAA}}, {32'hAAAAAAAA, 32'h2, 32'hAAAAAAAA, 32'h2}};
    tbl[4]  = '{2'd0, 2'd3, 1'b1, 5'd1, {2{64'h7FFFFFFFFFFFFFFF}}, {2{64'h7FFFFFFFFFFFFFFF}}, '0,
                128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 128'hDEADBEEF_CAFEF00D_FFFFFFFF_FFFFFFFE};
    tbl[5]  = '{2'd0, 2'd3, 1'b1, 5'd0, {2{64'h7FFFFFFFFFFFFFFF}}, {2{64'h7FFFFFFFFFFFFFFF}}, '0,
                128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF};
    tbl[6]  = '{2'd3, 2'd1, 1'b1, 5'd8, {8{16'hFFFF}}, {8{16'h0002}}, '0,
                '0, {8{16'h0001}}};
    tbl[7]  = '{2'd0, 2'd1, 1'b1, 5'd3, {8{16'h1000}}, {8{16'h0234}}, '0,
                {8{16'h5555}}, {{5{16'h5555}}, {3{16'h1234}}}};
    tbl[8]  = '{2'd1, 2'd0, 1'b1, 5'd20, '0, {16{8'h01}}, '0,
                '0, {16{8'hFF}}};
    tbl[9]  = '{2'd0, 2'd3, 1'b1, 5'd2, {2{64'h00000000FFFFFFFF}}, {2{64'h1}}, '0,
                '0, {2{64'h0000000100000000}}};
    tbl[10] = '{2'd2, 2'd1, 1'b0, 5'd8, {8{16'h0001}}, {8{16'h0010}}, 128'h81,
                {8{16'hBEEF}}, {16'h000F, {6{16'hBEEF}}, 16'h000F}};

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid2", VLEN'(ov2), VLEN'(0));
    check("rst_vd2", vd2, '0);
    check("rst_in_ready2", VLEN'(ir2), VLEN'(1));
    check("rst_out_valid4", VLEN'(ov4), VLEN'(0));
    check("rst_vd4", vd4, '0);
    check("rst_in_ready4", VLEN'(ir4), VLEN'(1));
    @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 0; i < NT; i++) run_vec(i, 1);
    sel = 1'b1;
    run_vec(4, 3);
    run_vec(10, 3);

    sel = 1'b0;
    rand_run(400);
    bp_test(2);
    sel = 1'b1;
    rand_run(400);
    bp_test(4);

    // Reset with two bundles in flight on the STAGES=2 instance.
    sel = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rand_bundle();
      in_valid = 1'b1;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    check("midrst_out_valid", VLEN'(ov2), VLEN'(0));
    check("midrst_vd", vd2, '0);
    check("midrst_in_ready", VLEN'(ir2), VLEN'(1));
    repeat (3) begin
      @(posedge clock);
      @(negedge clock);
      check("midrst_no_output", VLEN'(ov2), VLEN'(0));
    end
    @(posedge clock); #1;
    exp_q.delete();
    run_vec(3, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

endmodule
